// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo datapath: transmit-sequencer
// state encoding, CR/LF byte values and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        GUARD     = 2'd2,
        LF_LAUNCH = 2'd3
    } tx_state_e;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Push/pop bus between the transmit sequencer (master) and the byte FIFO (slave).
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              push;
    logic [7:0]        push_data;
    logic              pop;
    logic [7:0]        head;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output push, push_data, pop,
        input  head, count, full, empty
    );

    modport slave (
        input  push, push_data, pop,
        output head, count, full, empty
    );

endinterface

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO: DEPTH entries (power of two), first-word-fall-through
// head, occupancy count and full/empty flags. A push while full only lands
// when a pop frees a slot in the same cycle.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_queue_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              wr_en;
    logic              rd_en;

    assign rd_en = bus.pop && (count_q != '0);
    assign wr_en = bus.push && ((count_q != DEPTH_CNT) || rd_en);

    always_comb begin
        // NOTE: assign a default before any branch so count_d is driven on every path and no latch is inferred.
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign bus.head  = mem_q[rd_ptr_q];
    assign bus.count = count_q;
    assign bus.full  = (count_q == DEPTH_CNT);
    assign bus.empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and transmit sequencer between uart_rx and uart_tx. Optional
// feature macro UART_TX_QUEUE_CRLF_EN appends LF after every transmitted CR.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Full,
    output logic              o_Empty,
    output logic              o_Overflow
);

    uart_tx_queue_if #(.DEPTH(DEPTH)) fifo_bus ();

    sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .bus   (fifo_bus)
    );

    tx_state_e   state_q;
    logic        tx_dv_q;
    logic [7:0]  tx_byte_q;
    logic        overflow_q;
    logic        launch;

    // Pop and launch share one condition, so the head leaves the FIFO on the
    // same edge that raises o_Tx_DV.
    assign launch = (state_q == IDLE) && !fifo_bus.empty && !i_Tx_Active;

    assign fifo_bus.push      = i_Rx_DV;
    assign fifo_bus.push_data = i_Rx_Byte;
    assign fifo_bus.pop       = launch;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= IDLE;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            tx_dv_q <= 1'b0;
            if (i_Rx_DV && fifo_bus.full && !launch) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= fifo_bus.head;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_Tx_Done) begin
                        state_q <= GUARD;
                    end
                end
                GUARD: begin
`ifdef UART_TX_QUEUE_CRLF_EN
                    // tx_byte_q still holds the byte just sent; an LF never re-triggers.
                    state_q <= (tx_byte_q == CR) ? LF_LAUNCH : IDLE;
`else
                    state_q <= IDLE;
`endif
                end
`ifdef UART_TX_QUEUE_CRLF_EN
                LF_LAUNCH: begin
                    if (!i_Tx_Active) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= LF;
                        state_q   <= BUSY;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Count    = fifo_bus.count;
    assign o_Full     = fifo_bus.full;
    assign o_Empty    = fifo_bus.empty;
    assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a stub uart_tx and a byte scoreboard;
// also covers the CR->LF path when UART_TX_QUEUE_CRLF_EN is defined.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_dv     = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Count     (count),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Overflow  (overflow)
    );

    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [7:0] exp_q[$];
    int         lag       = 10;
    bit         done_en   = 1'b1;
    int         cyc       = 0;
    int         done_cyc  = -100;
    bit         gap_armed = 1'b0;
    int         sent      = 0;
    int         remaining = 0;
    logic       prev_dv   = 1'b0;
    logic [7:0] cur_byte  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stub uart_tx: goes active on DV, raises Done `lag` cycles later (when
    // enabled) and drops Active with it; checks every launched byte.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                tx_active = 1'b0;
                tx_done   = 1'b0;
                remaining = 0;
                prev_dv   = 1'b0;
                gap_armed = 1'b0;
            end else begin
                tx_done = 1'b0;
                if (tx_dv) begin
                    check("dv_one_cycle", 32'(prev_dv), 0);
                    check("dv_while_busy", 32'(tx_active), 0);
                    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check("tx_byte_order", 32'(tx_byte), 32'(exp_q.pop_front()));
                    end
                    if (gap_armed) begin
                        check("done_to_dv_cycles", 32'(cyc - done_cyc - 1), 2);
                    end
                    gap_armed = 1'b0;
                    cur_byte  = tx_byte;
                    tx_active = 1'b1;
                    remaining = lag;
                    sent++;
                end else if (tx_active) begin
                    if (remaining > 0) begin
                        remaining--;
                    end else if (done_en) begin
                        check("byte_hold", 32'(tx_byte), 32'(cur_byte));
                        tx_done   = 1'b1;
                        tx_active = 1'b0;
                        done_cyc  = cyc;
                        gap_armed = (exp_q.size() != 0);
                    end
                end
                prev_dv = tx_dv;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_rx(input logic [7:0] b, input bit expect_tx);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        if (expect_tx) begin
            exp_q.push_back(b);
`ifdef UART_TX_QUEUE_CRLF_EN
            if (b == CR) exp_q.push_back(LF);
`endif
        end
    endtask

    task automatic rx_idle();
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (i < budget && !(exp_q.size() == 0 && !tx_active && empty && !tx_dv)) begin
            @(negedge clk);
            i++;
        end
        repeat (4) @(negedge clk);
        check("drain_sb_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        int k;

        // Reset state
        #12;
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte: DV one cycle after the push lands
        lag = 10; done_en = 1'b1;
        drive_rx(8'h41, 1'b1);
        rx_idle();
        check("single_count_after_push", 32'(count), 1);
        check("single_no_dv_yet", 32'(tx_dv), 0);
        @(negedge clk);
        check("single_dv", 32'(tx_dv), 1);
        check("single_byte", 32'(tx_byte), 32'h41);
        check("single_count_after_pop", 32'(count), 0);
        check("single_empty", 32'(empty), 1);
        wait_drain(200);
        check("single_sent", 32'(sent), 1);

        // Burst 31..35 with slow Done: occupancy 1,1,2,3 then peak 4
        lag = 1040;
        for (int i = 0; i < 5; i++) begin
            drive_rx(8'h31 + 8'(i), 1'b1);
            if (i == 1) check("burst_count_1", 32'(count), 1);
            if (i == 2) check("burst_count_2", 32'(count), 1);
            if (i == 3) check("burst_count_3", 32'(count), 2);
            if (i == 4) check("burst_count_4", 32'(count), 3);
        end
        rx_idle();
        check("burst_peak", 32'(count), 4);
        wait_drain(8000);
        check("burst_sent", 32'(sent), 6);

        // Overflow: Done held off, 18 pushes, byte 18 dropped
        lag = 4; done_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive_rx(8'h50 + 8'(i), i < 17);
            if (i == 17) begin
                check("ovf_count_17", 32'(count), 16);
                check("ovf_full_17", 32'(full), 1);
                check("ovf_flag_17", 32'(overflow), 0);
            end
        end
        rx_idle();
        check("ovf_count_18", 32'(count), 16);
        check("ovf_flag_18", 32'(overflow), 1);
        check("ovf_first_launched", 32'(tx_byte), 32'h50);
        done_en = 1'b1;
        wait_drain(3000);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_drained_empty", 32'(empty), 1);
        check("ovf_drained_count", 32'(count), 0);

        // Push coinciding with the IDLE pop while full
        pulse_reset();
        check("post_reset_overflow", 32'(overflow), 0);
        done_en = 1'b0;
        for (int i = 0; i < 17; i++) drive_rx(8'h60 + 8'(i), 1'b1);
        rx_idle();
        check("simul_full_before", 32'(full), 1);
        done_en = 1'b1;
        k = 0;
        while (!tx_done && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("simul_done_seen", 32'(tx_done), 1);
        @(negedge clk);
        drive_rx(8'h7A, 1'b1);
        rx_idle();
        check("simul_pop_dv", 32'(tx_dv), 1);
        check("simul_pop_byte", 32'(tx_byte), 32'h61);
        check("simul_count", 32'(count), 16);
        check("simul_no_overflow", 32'(overflow), 0);
        wait_drain(3000);
        check("simul_drain_overflow", 32'(overflow), 0);

        // Async reset mid-BUSY with 3 bytes queued
        lag = 50;
        for (int i = 0; i < 4; i++) drive_rx(8'h21 + 8'(i), 1'b1);
        rx_idle();
        check("arst_queued", 32'(count), 3);
        repeat (5) @(negedge clk);
        check("arst_stub_busy", 32'(tx_active), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_tx_dv", 32'(tx_dv), 0);
        check("arst_tx_byte", 32'(tx_byte), 0);
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s = sent;
        repeat (50) @(negedge clk);
        check("arst_no_dv_after", 32'(sent - s), 0);
        check("arst_empty_after", 32'(empty), 1);

        // CR handling: LF appended only when the feature is built in
        lag = 6;
        s = sent;
        drive_rx(CR, 1'b1);
        rx_idle();
        check("cr_count_push", 32'(count), 1);
        @(negedge clk);
        check("cr_dv", 32'(tx_dv), 1);
        check("cr_byte", 32'(tx_byte), 32'h0D);
        check("cr_count_pop", 32'(count), 0);
        wait_drain(300);
        check("cr_count_final", 32'(count), 0);
`ifdef UART_TX_QUEUE_CRLF_EN
        check("cr_sent_pair", 32'(sent - s), 2);
        check("cr_last_byte", 32'(tx_byte), 32'h0A);
`else
        check("cr_sent_verbatim", 32'(sent - s), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
